id_ex_fwd_reg: RTL and testbench
================================

Name: id_ex_fwd_reg

Overview:
- ID/EX pipeline register for the 5-stage RISC-V core; sits directly upstream of the EX-stage operand forwarding muxes (4-input, 2-bit select).
- Captures decoded operands and control from ID, supports stall (hold) and flush (bubble).
- Computes the forwarding selects one cycle early and presents them as registered outputs, so the muxes see no compare logic in EX.
- While holding, absorbs register-file writeback into the held operands so they never go stale.

Parameters:
DATA_W, 32, operand / PC / immediate width
REG_AW, 5, register address width
CTRL_W, 16, opaque EX/MEM/WB control bundle width (excludes regwrite)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold ID/EX contents; EX/MEM receives a bubble this cycle
flush  in  1  load a bubble; priority over stall
id_valid  in  1  ID holds a real instruction
id_pc  in  DATA_W  instruction PC
id_rs1_data, id_rs2_data  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_rs1, id_rs2, id_rd  in  REG_AW  register addresses
id_regwrite  in  1  instruction writes rd
id_ctrl  in  CTRL_W  control bundle
mem_rd_i, mem_we_i  in  REG_AW, 1  EX/MEM dest / write-enable (valid-gated upstream)
wb_rd_i, wb_we_i  in  REG_AW, 1  MEM/WB dest / write-enable
wb_data_i  in  DATA_W  data written to register file this cycle
q_valid, q_pc, q_rs1_data, q_rs2_data, q_imm, q_rs1, q_rs2, q_rd, q_regwrite, q_ctrl  out  as inputs  registered ID/EX fields
q_fwd_a, q_fwd_b  out  2  forwarding selects: 00 = register data, 01 = MEM/WB, 10 = EX/MEM, 11 = never driven

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. While rst_n = 0, all q_* outputs are 0, so q_fwd_* = 00.
- Latency: one cycle from the ID inputs to the q_* outputs.
- Validity gating: q_regwrite is registered as id_regwrite AND id_valid. A bubble has q_valid = 0, q_regwrite = 0, q_ctrl = 0 and q_fwd_* = 00. Data fields of a bubble are don't-care and are zeroed.
- Priority of updates: flush > stall > advance.
- flush = 1: load a bubble, regardless of stall.
- Advance (stall = 0, flush = 0): capture the ID fields. For each source rsX (X = 1, 2), in priority order:
  - rsX == 0: select 00; captured data = register-file read data.
  - q_regwrite AND q_rd == rsX (the current EX instruction, which becomes EX/MEM next cycle): select 10.
  - else mem_we_i AND mem_rd_i == rsX: select 01.
  - else wb_we_i AND wb_rd_i == rsX: select 00 and capture wb_data_i in place of the register-file data (write/read same-cycle bypass).
  - else: select 00; captured data = register-file read data.
- Stall (stall = 1, flush = 0): all fields hold except q_rsX_data and q_fwd_X, which are recomputed from the held q_rsX:
  - 10 is impossible, because EX/MEM gets a bubble.
  - mem_we_i AND mem_rd_i == q_rsX: select 01.
  - else wb_we_i AND wb_rd_i == q_rsX: q_rsX_data <= wb_data_i, select 00.
  - else: select unchanged if 00; if previously 01 and no match, the value has retired through WB. That case is covered by the wb match the previous cycle, so select 00.
- Load-use hazards are excluded by the external hazard unit, which bubbles ID/EX. This block never checks memread.
- Reset deasserting mid-stream: the first capture happens on the first clock edge with rst_n = 1.
- Simultaneous flush and stall: the bubble is taken and the stall is ignored for this register.

Decomposition:
- Shared package pipe_pkg holds:
  - fwd_sel_e: FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - DATA_W, REG_AW and CTRL_W defaults.
  - the control-bundle typedef.
- One combinational sub-module, fwd_predict, instantiated twice (rs1, rs2):
  - inputs: rs, held flag, q_rd/q_regwrite, mem_rd/we, wb_rd/we.
  - outputs: next select and a capture-wb flag.

Test Plan:
- Reset: drive rst_n = 0 mid-cycle with all inputs nonzero -> all q_* = 0 immediately (asynchronous); after release with id_valid = 1, pc = 0x100 -> q_pc = 0x100 and q_valid = 1 after one edge.
- EX/MEM forwarding priority:
  - setup: q_rd = 5 and q_regwrite = 1 in ID/EX, mem_rd_i = 5 with mem_we_i = 1, id_rs1 = 5, advance.
  - expected: q_fwd_a = 10.
  - id_rs2 = 0 with every rd = 0 -> q_fwd_b = 00.
- WB bypass on advance: wb_rd_i = 7, wb_we_i = 1, wb_data_i = 0xDEADBEEF, id_rs2 = 7, id_rs2_data = 0x1 -> q_rs2_data = 0xDEADBEEF, q_fwd_b = 00.
- Stall retirement:
  - cycle 0: held q_rs1 = 3 with q_fwd_a = 01.
  - cycle 1: stall = 1 with mem_we_i = 0, wb_rd_i = 3, wb_we_i = 1, wb_data_i = 0x55 -> q_rs1_data = 0x55, q_fwd_a = 00.
  - other fields unchanged.
- Flush over stall: stall = 1 and flush = 1 together -> q_valid = 0, q_regwrite = 0, q_ctrl = 0, q_fwd_a = q_fwd_b = 00.
- Invalid input: id_valid = 0, id_regwrite = 1, id_rd = 9 -> q_regwrite = 0. Next instruction with id_rs1 = 9 -> q_fwd_a ≠ 10.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the 5-stage core: forwarding-select encoding,
// default datapath widths and the opaque EX/MEM/WB control bundle.
package pipe_pkg;

  localparam int DATA_W_DFLT = 32;
  localparam int REG_AW_DFLT = 5;
  localparam int CTRL_W_DFLT = 16;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef logic [CTRL_W_DFLT-1:0] ctrl_t;

endpackage

// File: rtl/id_ex_fwd_reg_if.sv
// ID/EX register bundle: ID-side inputs, EX/MEM and MEM/WB snoop ports,
// and the registered ID/EX fields with their precomputed forwarding selects.
interface id_ex_fwd_reg_if #(
  parameter int DATA_W = pipe_pkg::DATA_W_DFLT,
  parameter int REG_AW = pipe_pkg::REG_AW_DFLT,
  parameter int CTRL_W = pipe_pkg::CTRL_W_DFLT
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_rs1_data;
  logic [DATA_W-1:0] id_rs2_data;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic [CTRL_W-1:0] id_ctrl;
  logic [REG_AW-1:0] mem_rd_i;
  logic              mem_we_i;
  logic [REG_AW-1:0] wb_rd_i;
  logic              wb_we_i;
  logic [DATA_W-1:0] wb_data_i;

  logic              q_valid;
  logic [DATA_W-1:0] q_pc;
  logic [DATA_W-1:0] q_rs1_data;
  logic [DATA_W-1:0] q_rs2_data;
  logic [DATA_W-1:0] q_imm;
  logic [REG_AW-1:0] q_rs1;
  logic [REG_AW-1:0] q_rs2;
  logic [REG_AW-1:0] q_rd;
  logic              q_regwrite;
  logic [CTRL_W-1:0] q_ctrl;
  logic [1:0]        q_fwd_a;
  logic [1:0]        q_fwd_b;

  modport master (
    output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_regwrite, id_ctrl,
           mem_rd_i, mem_we_i, wb_rd_i, wb_we_i, wb_data_i,
    input  q_valid, q_pc, q_rs1_data, q_rs2_data, q_imm, q_rs1, q_rs2, q_rd,
           q_regwrite, q_ctrl, q_fwd_a, q_fwd_b
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_regwrite, id_ctrl,
           mem_rd_i, mem_we_i, wb_rd_i, wb_we_i, wb_data_i,
    output q_valid, q_pc, q_rs1_data, q_rs2_data, q_imm, q_rs1, q_rs2, q_rd,
           q_regwrite, q_ctrl, q_fwd_a, q_fwd_b
  );

endinterface

// File: rtl/id_ex_fwd_reg_fwd_predict.sv
// Next-cycle forwarding select for one source operand, plus a flag telling
// the register to take the writeback data in place of its current operand.
module fwd_predict
  import pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DFLT
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_held,
  input  logic [REG_AW-1:0] i_q_rd,
  input  logic              i_q_regwrite,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_we,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic              i_wb_we,
  output fwd_sel_e          o_sel,
  output logic              o_cap_wb
);

  logic w_rs_nz;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  // While held, EX/MEM receives a bubble, so the EX instruction never forwards.
  assign w_rs_nz   = (i_rs != '0);
  assign w_ex_hit  = !i_held && i_q_regwrite && (i_q_rd == i_rs);
  assign w_mem_hit = i_mem_we && (i_mem_rd == i_rs);
  assign w_wb_hit  = i_wb_we && (i_wb_rd == i_rs);

  always_comb begin
    o_sel    = FWD_REG;
    o_cap_wb = 1'b0;
    if (w_rs_nz) begin
      if (w_ex_hit) begin
        o_sel = FWD_MEM;
      end else if (w_mem_hit) begin
        o_sel = FWD_WB;
      end else if (w_wb_hit) begin
        o_cap_wb = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register with stall/flush and registered forwarding selects;
// held operands absorb register-file writeback so they never go stale.
module id_ex_fwd_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int REG_AW = REG_AW_DFLT,
  parameter int CTRL_W = CTRL_W_DFLT
) (
  input logic           clk,
  input logic           rst_n,
  id_ex_fwd_reg_if.slave bus
);

  logic              r_valid;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic              r_regwrite;
  logic [CTRL_W-1:0] r_ctrl;
  fwd_sel_e          r_fwd_a;
  fwd_sel_e          r_fwd_b;

  logic              w_bubble;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  fwd_sel_e          w_sel_a;
  fwd_sel_e          w_sel_b;
  logic              w_cap_a;
  logic              w_cap_b;

  // An invalid ID slot on advance is loaded as a bubble, same as a flush.
  assign w_bubble = bus.flush || (!bus.stall && !bus.id_valid);
  assign w_rs1    = bus.stall ? r_rs1 : bus.id_rs1;
  assign w_rs2    = bus.stall ? r_rs2 : bus.id_rs2;

  fwd_predict #(.REG_AW(REG_AW)) u_pred_a (
    .i_rs         (w_rs1),
    .i_held       (bus.stall),
    .i_q_rd       (r_rd),
    .i_q_regwrite (r_regwrite),
    .i_mem_rd     (bus.mem_rd_i),
    .i_mem_we     (bus.mem_we_i),
    .i_wb_rd      (bus.wb_rd_i),
    .i_wb_we      (bus.wb_we_i),
    .o_sel        (w_sel_a),
    .o_cap_wb     (w_cap_a)
  );

  fwd_predict #(.REG_AW(REG_AW)) u_pred_b (
    .i_rs         (w_rs2),
    .i_held       (bus.stall),
    .i_q_rd       (r_rd),
    .i_q_regwrite (r_regwrite),
    .i_mem_rd     (bus.mem_rd_i),
    .i_mem_we     (bus.mem_we_i),
    .i_wb_rd      (bus.wb_rd_i),
    .i_wb_we      (bus.wb_we_i),
    .o_sel        (w_sel_b),
    .o_cap_wb     (w_cap_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_ctrl     <= '0;
      r_fwd_a    <= FWD_REG;
      r_fwd_b    <= FWD_REG;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_ctrl     <= '0;
      r_fwd_a    <= FWD_REG;
      r_fwd_b    <= FWD_REG;
    end else if (bus.stall) begin
      if (w_cap_a) r_rs1_data <= bus.wb_data_i;
      if (w_cap_b) r_rs2_data <= bus.wb_data_i;
      r_fwd_a <= w_sel_a;
      r_fwd_b <= w_sel_b;
    end else begin
      r_valid    <= 1'b1;
      r_pc       <= bus.id_pc;
      r_rs1_data <= w_cap_a ? bus.wb_data_i : bus.id_rs1_data;
      r_rs2_data <= w_cap_b ? bus.wb_data_i : bus.id_rs2_data;
      r_imm      <= bus.id_imm;
      r_rs1      <= bus.id_rs1;
      r_rs2      <= bus.id_rs2;
      r_rd       <= bus.id_rd;
      r_regwrite <= bus.id_regwrite;
      r_ctrl     <= bus.id_ctrl;
      r_fwd_a    <= w_sel_a;
      r_fwd_b    <= w_sel_b;
    end
  end

  assign bus.q_valid    = r_valid;
  assign bus.q_pc       = r_pc;
  assign bus.q_rs1_data = r_rs1_data;
  assign bus.q_rs2_data = r_rs2_data;
  assign bus.q_imm      = r_imm;
  assign bus.q_rs1      = r_rs1;
  assign bus.q_rs2      = r_rs2;
  assign bus.q_rd       = r_rd;
  assign bus.q_regwrite = r_regwrite;
  assign bus.q_ctrl     = r_ctrl;
  assign bus.q_fwd_a    = r_fwd_a;
  assign bus.q_fwd_b    = r_fwd_b;

endmodule

// File: tb/tb_id_ex_fwd_reg.sv
// Directed bench for id_ex_fwd_reg: reset, forwarding priority, WB bypass,
// stall retirement, flush over stall and invalid-slot gating.
module tb_id_ex_fwd_reg;
  import pipe_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  id_ex_fwd_reg_if bus ();

  id_ex_fwd_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.id_valid    = 1'b1;
    bus.id_pc       = '0;
    bus.id_rs1_data = '0;
    bus.id_rs2_data = '0;
    bus.id_imm      = '0;
    bus.id_rs1      = '0;
    bus.id_rs2      = '0;
    bus.id_rd       = '0;
    bus.id_regwrite = 1'b0;
    bus.id_ctrl     = '0;
    bus.mem_rd_i    = '0;
    bus.mem_we_i    = 1'b0;
    bus.wb_rd_i     = '0;
    bus.wb_we_i     = 1'b0;
    bus.wb_data_i   = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_inputs();
    // all inputs nonzero, no address matches between sources and rd/mem/wb
    bus.id_pc       = 32'h200;
    bus.id_rs1_data = 32'h11;
    bus.id_rs2_data = 32'h22;
    bus.id_imm      = 32'h33;
    bus.id_rs1      = 5'd1;
    bus.id_rs2      = 5'd2;
    bus.id_rd       = 5'd4;
    bus.id_regwrite = 1'b1;
    bus.id_ctrl     = 16'hA5A5;
    bus.mem_rd_i    = 5'd6;
    bus.mem_we_i    = 1'b1;
    bus.wb_rd_i     = 5'd8;
    bus.wb_we_i     = 1'b1;
    bus.wb_data_i   = 32'h99;
    #12 rst_n = 1'b1;
    step();
    step();
    check("pre_valid", 64'(bus.q_valid), 64'd1);
    check("pre_pc", 64'(bus.q_pc), 64'h200);
    check("pre_ctrl", 64'(bus.q_ctrl), 64'hA5A5);

    // asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(bus.q_valid), 64'd0);
    check("rst_data", {bus.q_pc, bus.q_rs1_data}, 64'd0);
    check("rst_data2", {bus.q_rs2_data, bus.q_imm}, 64'd0);
    check("rst_addr", 64'({bus.q_rs1, bus.q_rs2, bus.q_rd}), 64'd0);
    check("rst_rw_ctrl", 64'({bus.q_regwrite, bus.q_ctrl}), 64'd0);
    check("rst_fwd", 64'({bus.q_fwd_a, bus.q_fwd_b}), 64'd0);

    clear_inputs();
    bus.id_pc = 32'h100;
    #2 rst_n = 1'b1;
    step();
    check("rel_pc", 64'(bus.q_pc), 64'h100);
    check("rel_valid", 64'(bus.q_valid), 64'd1);

    // EX instruction writes x5
    clear_inputs();
    bus.id_rd       = 5'd5;
    bus.id_regwrite = 1'b1;
    step();
    check("ex_setup_rw", 64'({bus.q_regwrite, bus.q_rd}), 64'h25);
    // rs1 = 5 matches both EX and EX/MEM; EX wins
    clear_inputs();
    bus.id_rs1      = 5'd5;
    bus.id_rs1_data = 32'h1234;
    bus.mem_rd_i    = 5'd5;
    bus.mem_we_i    = 1'b1;
    step();
    check("exmem_fwd_a", 64'(bus.q_fwd_a), 64'(FWD_MEM));
    check("zero_fwd_b", 64'(bus.q_fwd_b), 64'(FWD_REG));
    // EX now writes nothing; only EX/MEM matches
    step();
    check("mem_only_fwd_a", 64'(bus.q_fwd_a), 64'(FWD_WB));
    check("mem_only_data", 64'(bus.q_rs1_data), 64'h1234);

    // same-cycle register-file write/read bypass
    clear_inputs();
    bus.wb_rd_i     = 5'd7;
    bus.wb_we_i     = 1'b1;
    bus.wb_data_i   = 32'hDEADBEEF;
    bus.id_rs2      = 5'd7;
    bus.id_rs2_data = 32'h1;
    step();
    check("wb_byp_data", 64'(bus.q_rs2_data), 64'hDEADBEEF);
    check("wb_byp_fwd_b", 64'(bus.q_fwd_b), 64'(FWD_REG));

    // held instruction reading x3 from EX/MEM
    clear_inputs();
    bus.id_pc       = 32'h300;
    bus.id_rs1      = 5'd3;
    bus.id_rs1_data = 32'hAA;
    bus.id_rd       = 5'd10;
    bus.id_regwrite = 1'b1;
    bus.id_ctrl     = 16'h1234;
    bus.id_imm      = 32'h44;
    bus.mem_rd_i    = 5'd3;
    bus.mem_we_i    = 1'b1;
    step();
    check("stall_setup_fwd_a", 64'(bus.q_fwd_a), 64'(FWD_WB));
    // stall: x3 still in EX/MEM keeps select 01
    clear_inputs();
    bus.stall    = 1'b1;
    bus.id_pc    = 32'h999;
    bus.id_rs1   = 5'd12;
    bus.mem_rd_i = 5'd3;
    bus.mem_we_i = 1'b1;
    step();
    check("stall_mem_fwd_a", 64'(bus.q_fwd_a), 64'(FWD_WB));
    // stall: x3 retires through WB into the held operand
    bus.mem_we_i  = 1'b0;
    bus.wb_rd_i   = 5'd3;
    bus.wb_we_i   = 1'b1;
    bus.wb_data_i = 32'h55;
    step();
    check("retire_data", 64'(bus.q_rs1_data), 64'h55);
    check("retire_fwd_a", 64'(bus.q_fwd_a), 64'(FWD_REG));
    check("hold_pc", 64'(bus.q_pc), 64'h300);
    check("hold_rd_rw", 64'({bus.q_regwrite, bus.q_rd}), 64'h2A);
    check("hold_ctrl_imm", {16'd0, bus.q_ctrl, bus.q_imm}, 64'h0000_1234_0000_0044);
    check("hold_valid_rs1", 64'({bus.q_valid, bus.q_rs1}), 64'h23);

    // flush beats stall
    bus.flush = 1'b1;
    step();
    check("flush_valid_rw", 64'({bus.q_valid, bus.q_regwrite}), 64'd0);
    check("flush_ctrl", 64'(bus.q_ctrl), 64'd0);
    check("flush_fwd", 64'({bus.q_fwd_a, bus.q_fwd_b}), 64'd0);

    // invalid slot never claims a write
    clear_inputs();
    bus.id_valid    = 1'b0;
    bus.id_regwrite = 1'b1;
    bus.id_rd       = 5'd9;
    step();
    check("inv_regwrite", 64'(bus.q_regwrite), 64'd0);
    check("inv_valid", 64'(bus.q_valid), 64'd0);
    clear_inputs();
    bus.id_rs1 = 5'd9;
    step();
    check("inv_next_fwd_a", 64'(bus.q_fwd_a), 64'(FWD_REG));
    check("inv_next_valid", 64'(bus.q_valid), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
